// File: rtl/gc_dram_host_master.sv
`default_nettype none
// ============================================================================
// Module      : gc_dram_host_master
// Description : Host initiator for the gain-cell DRAM controller. Requests are
//               queued in order and issued on the controller pins. Read data
//               is returned to the client over a valid/ready channel.
// Revision    : 1.0 - initial release
// ============================================================================
module gc_dram_host_master #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_disable_ref,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_disable_ref
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(RD_LAT + 1);
    localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_RD_LAT  = c_CNT_W'(RD_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_GAP   = 3'd2,
        S_READ  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_lat_cnt;

    logic                r_fifo_we   [FIFO_DEPTH];
    logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_count;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_head_we;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [DATA_W-1:0]   w_head_data;

    assign w_full      = (r_count == c_FULL);
    assign w_empty     = (r_count == '0);
    assign req_ready   = !w_full && !rst;
    assign w_push      = req_valid && req_ready;
    assign w_pop       = (r_state == S_IDLE) && !w_empty && !mem_busy;
    assign w_head_we   = r_fifo_we[r_rd_ptr];
    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_we[r_wr_ptr]   <= req_we;
            r_fifo_addr[r_wr_ptr] <= req_addr;
            r_fifo_data[r_wr_ptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            r_count <= r_count + (c_PTR_W + 1)'(w_push) - (c_PTR_W + 1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_lat_cnt       <= '0;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            mem_we          <= 1'b0;
            mem_re          <= 1'b0;
            mem_waddr       <= '0;
            mem_raddr       <= '0;
            mem_in          <= '0;
            mem_disable_ref <= 1'b0;
        end else begin
            mem_disable_ref <= cfg_disable_ref;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (w_head_we) begin
                            mem_we    <= 1'b1;
                            mem_waddr <= w_head_addr;
                            mem_in    <= w_head_data;
                            r_state   <= S_WRITE;
                        end else begin
                            mem_re    <= 1'b1;
                            mem_raddr <= w_head_addr;
                            r_lat_cnt <= '0;
                            r_state   <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    mem_we <= 1'b0;
                    // A read right behind a write to the same cell gets one spare cycle.
                    if (!w_empty && !w_head_we && (w_head_addr == mem_waddr)) begin
                        r_state <= S_GAP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                S_READ: begin
                    if (mem_busy) begin
                        r_lat_cnt <= '0;
                    end else if (r_lat_cnt == c_RD_LAT) begin
                        rsp_data  <= mem_rd;
                        rsp_valid <= 1'b1;
                        mem_re    <= 1'b0;
                        r_state   <= S_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + c_CNT_ONE;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gc_dram_host_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_gc_dram_host_master
// Description : Scoreboard bench for gc_dram_host_master with a simple
//               controller model driving mem_rd.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gc_dram_host_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_disable_ref;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        mem_busy;
    logic [63:0] mem_rd;
    logic        mem_we;
    logic        mem_re;
    logic [9:0]  mem_waddr;
    logic [9:0]  mem_raddr;
    logic [63:0] mem_in;
    logic        mem_disable_ref;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q [$];
    logic [63:0] shadow [1024];
    logic [63:0] ctl_mem [1024];

    localparam logic [63:0] c_D0 = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] c_D1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] c_D2 = 64'hA5A5_5A5A_0F0F_F0F0;
    localparam logic [63:0] c_D3 = 64'h0123_4567_89AB_CDEF;

    gc_dram_host_master dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_disable_ref (cfg_disable_ref),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .mem_busy        (mem_busy),
        .mem_rd          (mem_rd),
        .mem_we          (mem_we),
        .mem_re          (mem_re),
        .mem_waddr       (mem_waddr),
        .mem_raddr       (mem_raddr),
        .mem_in          (mem_in),
        .mem_disable_ref (mem_disable_ref)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            shadow[i]  = '0;
            ctl_mem[i] = '0;
        end
    end

    // Controller model: registered read port, write on edge.
    always @(posedge clk) begin
        if (mem_we) ctl_mem[mem_waddr] <= mem_in;
        mem_rd <= mem_re ? ctl_mem[mem_raddr] : 64'h0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected queue on every response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            check("we_re_exclusive", {63'h0, mem_we & mem_re}, 64'h0);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got %h expected none", rsp_data);
                end else begin
                    check("rsp_data", rsp_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic push(input logic we, input logic [9:0] a, input logic [63:0] d);
        int t = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) begin
            check("push_timeout", 64'h1, 64'h0);
        end else begin
            @(posedge clk); #1;
            if (we) shadow[a] = d;
            else    exp_q.push_back(shadow[a]);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic wait_mem_re();
        int t = 0;
        while (!mem_re && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("mem_re_seen", {63'h0, mem_re}, 64'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic we_s [12];
        logic re_s [12];
        int   we_len, last_we, first_re, t;

        rst = 1'b1; cfg_disable_ref = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1; mem_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("req_ready_in_reset", {63'h0, req_ready}, 64'h0);
        rst = 1'b0;
        #1;
        check("req_ready_after_reset", {63'h0, req_ready}, 64'h1);
        check("rsp_valid_reset", {63'h0, rsp_valid}, 64'h0);
        check("rsp_data_reset", rsp_data, 64'h0);
        check("mem_we_reset", {63'h0, mem_we}, 64'h0);
        check("mem_re_reset", {63'h0, mem_re}, 64'h0);
        check("mem_waddr_reset", {54'h0, mem_waddr}, 64'h0);
        check("mem_raddr_reset", {54'h0, mem_raddr}, 64'h0);
        check("mem_in_reset", mem_in, 64'h0);
        check("mem_disable_ref_reset", {63'h0, mem_disable_ref}, 64'h0);

        // Write then read the same address: 1-cycle write pulse, 2 idle cycles before read.
        push(1'b1, 10'h155, c_D0);
        push(1'b0, 10'h155, 64'h0);
        for (int i = 0; i < 12; i++) begin
            we_s[i] = mem_we;
            re_s[i] = mem_re;
            @(posedge clk); #1;
        end
        we_len = 0; last_we = -1; first_re = -1;
        for (int i = 0; i < 12; i++) begin
            if (we_s[i]) begin we_len++; last_we = i; end
            if (re_s[i] && first_re < 0) first_re = i;
        end
        check("we_pulse_len", 64'(we_len), 64'd1);
        check("gap_cycles", 64'(first_re - last_we - 1), 64'd2);
        wait_drain();

        // FIFO fills while the controller is busy; fifth request waits.
        mem_busy = 1'b1;
        push(1'b1, 10'h010, c_D1);
        push(1'b1, 10'h020, c_D2);
        push(1'b0, 10'h010, 64'h0);
        push(1'b0, 10'h020, 64'h0);
        check("req_ready_full", {63'h0, req_ready}, 64'h0);
        check("no_issue_when_busy", {62'h0, mem_we, mem_re}, 64'h0);
        mem_busy = 1'b0;
        push(1'b0, 10'h155, 64'h0);
        wait_drain();

        // Busy during a read restarts the latency count.
        push(1'b0, 10'h010, 64'h0);
        wait_mem_re();
        @(posedge clk); #1;
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_rsp_while_busy", {63'h0, rsp_valid}, 64'h0);
        end
        mem_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("restart_no_early_rsp", {63'h0, rsp_valid}, 64'h0);
        wait_drain();

        // Response held while client stalls; FIFO still accepts.
        rsp_ready = 1'b0;
        push(1'b0, 10'h020, 64'h0);
        t = 0;
        while (!rsp_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        for (int i = 0; i < 10; i++) begin
            check("hold_rsp_valid", {63'h0, rsp_valid}, 64'h1);
            check("hold_rsp_data", rsp_data, c_D2);
            check("hold_no_mem_cmd", {62'h0, mem_we, mem_re}, 64'h0);
            if (i == 2) begin
                check("fifo_accepts_in_resp", {63'h0, req_ready}, 64'h1);
                push(1'b1, 10'h030, c_D3);
            end else begin
                @(posedge clk); #1;
            end
        end
        rsp_ready = 1'b1;
        wait_drain();
        repeat (4) @(posedge clk);
        #1;

        // Reset in the middle of a read discards it.
        push(1'b0, 10'h030, 64'h0);
        wait_mem_re();
        @(posedge clk); #1;
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        check("rst_mem_re", {63'h0, mem_re}, 64'h0);
        check("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        check("rst_req_ready_low", {63'h0, req_ready}, 64'h0);
        rst = 1'b0;
        #1;
        check("rst_req_ready_high", {63'h0, req_ready}, 64'h1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("no_stale_rsp", {63'h0, rsp_valid}, 64'h0);
        end

        // Refresh-disable follows one cycle later.
        cfg_disable_ref = 1'b1;
        #1;
        check("disable_ref_not_yet", {63'h0, mem_disable_ref}, 64'h0);
        @(posedge clk); #1;
        check("disable_ref_set", {63'h0, mem_disable_ref}, 64'h1);
        cfg_disable_ref = 1'b0;
        @(posedge clk); #1;
        check("disable_ref_clear", {63'h0, mem_disable_ref}, 64'h0);

        // Random write/read pairs.
        for (int i = 0; i < 32; i++) begin
            logic [9:0]  a;
            logic [63:0] d;
            a = 10'($urandom_range(0, 1023));
            d = {$urandom, $urandom};
            push(1'b1, a, d);
            push(1'b0, a, 64'h0);
        end
        wait_drain();
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
